// File: rtl/comp_strg_pkg.sv
// Shared types for the computational storage block: opcodes, FSM states
// and default geometry.
package comp_strg_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        CMD_READ  = 3'd0,
        CMD_WRITE = 3'd1,
        CMD_ADD   = 3'd2,
        CMD_SUB   = 3'd3,
        CMD_AND   = 3'd4,
        CMD_OR    = 3'd5,
        CMD_XOR   = 3'd6,
        CMD_RSVD  = 3'd7
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // ADD and SUB are the only opcodes that refuse identical operand addresses
    function automatic logic is_arith(input cmd_e c);
        return (c == CMD_ADD) || (c == CMD_SUB);
    endfunction

endpackage

// File: rtl/comp_strg_mc_if.sv
// Command/response bundle between a requester (master) and the
// computational storage block (slave).
interface comp_strg_mc_if #(
    parameter int DATA_W = comp_strg_pkg::DATA_W_DEF,
    parameter int ADDR_W = comp_strg_pkg::ADDR_W_DEF
);
    logic                 en;
    comp_strg_pkg::cmd_e  cmd;
    logic [ADDR_W-1:0]    addA;
    logic [ADDR_W-1:0]    addB;
    logic [ADDR_W-1:0]    addC;
    logic [DATA_W-1:0]    din;
    logic                 ready;
    logic                 valid_out;
    logic [DATA_W-1:0]    dout;
    logic                 err;
    logic                 ovf;

    modport master (
        output en, cmd, addA, addB, addC, din,
        input  ready, valid_out, dout, err, ovf
    );

    modport slave (
        input  en, cmd, addA, addB, addC, din,
        output ready, valid_out, dout, err, ovf
    );

endinterface

// File: rtl/comp_strg_alu.sv
// Combinational arithmetic/logic unit: unsigned ADD/SUB with optional
// saturation, bitwise AND/OR/XOR, and reserved-opcode detection.
module comp_strg_alu
    import comp_strg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter bit SAT_EN = 1'b0
) (
    input  cmd_e              i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result,
    output logic              o_ovf,
    output logic              o_err_op
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // The extra top bit carries the ADD carry-out or the SUB borrow
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Opcode decode; READ/WRITE produce nothing here, the top muxes them
    always_comb begin
        o_result = {DATA_W{1'b0}};
        o_ovf    = 1'b0;
        o_err_op = 1'b0;
        case (i_op)
            CMD_ADD: begin
                o_ovf    = w_sum[DATA_W];
                o_result = (SAT_EN && w_sum[DATA_W]) ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
            end
            CMD_SUB: begin
                o_ovf    = w_diff[DATA_W];
                o_result = (SAT_EN && w_diff[DATA_W]) ? {DATA_W{1'b0}} : w_diff[DATA_W-1:0];
            end
            CMD_AND:   o_result = i_a & i_b;
            CMD_OR:    o_result = i_a | i_b;
            CMD_XOR:   o_result = i_a ^ i_b;
            CMD_READ:  o_result = {DATA_W{1'b0}};
            CMD_WRITE: o_result = {DATA_W{1'b0}};
            CMD_RSVD:  o_err_op = 1'b1;
            default:   o_err_op = 1'b1;
        endcase
    end

endmodule

// File: rtl/comp_strg_mc.sv
// Computational storage block: a flop-based register file that executes one
// read/write/ALU command per three cycles (IDLE -> EXEC -> RESP).
module comp_strg_mc
    import comp_strg_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit SAT_EN = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    comp_strg_mc_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e              r_state;
    state_e              w_next_state;
    cmd_e                r_cmd;
    logic [ADDR_W-1:0]   r_addA;
    logic [ADDR_W-1:0]   r_addB;
    logic [ADDR_W-1:0]   r_addC;
    logic [DATA_W-1:0]   r_din;
    logic [DATA_W-1:0]   r_opa;
    logic [DATA_W-1:0]   r_opb;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_dout;
    logic                r_err;
    logic                r_ovf;

    logic [DATA_W-1:0]   w_alu_result;
    logic                w_alu_ovf;
    logic                w_alu_err;
    logic                w_err;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [DATA_W-1:0]   w_result;
    logic                w_ovf;
    logic                w_ready;
    logic                w_valid;

    comp_strg_alu #(
        .DATA_W (DATA_W),
        .SAT_EN (SAT_EN)
    ) u_alu (
        .i_op     (r_cmd),
        .i_a      (r_opa),
        .i_b      (r_opb),
        .o_result (w_alu_result),
        .o_ovf    (w_alu_ovf),
        .o_err_op (w_alu_err)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; en outside IDLE is simply not looked at
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.en) begin
                    w_next_state = ST_EXEC;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_EXEC: w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is held low throughout reset
    always_comb begin
        w_ready = 1'b0;
        w_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = ~rst;
            ST_EXEC: w_ready = 1'b0;
            ST_RESP: w_valid = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Command capture and operand fetch on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd  <= CMD_READ;
            r_addA <= {ADDR_W{1'b0}};
            r_addB <= {ADDR_W{1'b0}};
            r_addC <= {ADDR_W{1'b0}};
            r_din  <= {DATA_W{1'b0}};
            r_opa  <= {DATA_W{1'b0}};
            r_opb  <= {DATA_W{1'b0}};
        end else if ((r_state == ST_IDLE) && bus.en) begin
            r_cmd  <= bus.cmd;
            r_addA <= bus.addA;
            r_addB <= bus.addB;
            r_addC <= bus.addC;
            r_din  <= bus.din;
            r_opa  <= r_mem[bus.addA];
            r_opb  <= r_mem[bus.addB];
        end
    end

    // EXEC-cycle decode: result selection, write target and error gating
    always_comb begin
        w_err    = w_alu_err || (is_arith(r_cmd) && (r_addA == r_addB));
        w_we     = 1'b0;
        w_waddr  = r_addC;
        w_result = w_alu_result;
        w_ovf    = 1'b0;
        if (w_err) begin
            w_result = {DATA_W{1'b0}};
        end else begin
            case (r_cmd)
                CMD_READ: w_result = r_opa;
                CMD_WRITE: begin
                    w_we     = 1'b1;
                    w_waddr  = r_addA;
                    w_result = r_din;
                end
                default: begin
                    w_we  = 1'b1;
                    w_ovf = w_alu_ovf;
                end
            endcase
        end
    end

    // Storage array; reset wipes every word, so an aborted EXEC never writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem <= '{default: {DATA_W{1'b0}}};
        end else if ((r_state == ST_EXEC) && w_we) begin
            r_mem[w_waddr] <= w_result;
        end
    end

    // Response registers hold until the next EXEC overwrites them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= {DATA_W{1'b0}};
            r_err  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_dout <= w_result;
            r_err  <= w_err;
            r_ovf  <= w_ovf;
        end
    end

    assign bus.ready     = w_ready;
    assign bus.valid_out = w_valid;
    assign bus.dout      = r_dout;
    assign bus.err       = r_err;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_comp_strg_mc.sv
// Directed bench for comp_strg_mc: wrapping and saturating instances driven
// in lock-step, responses checked against a reference-model scoreboard.
module tb_comp_strg_mc;
    import comp_strg_pkg::*;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic        err;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    exp_t        sb[$];
    int          acc_q[$];
    logic [31:0] m0 [16];
    logic [31:0] m1 [16];
    int          n_pass   = 0;
    int          n_checks = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;

    comp_strg_mc_if #(.DATA_W(32), .ADDR_W(4)) bus0 ();
    comp_strg_mc_if #(.DATA_W(32), .ADDR_W(4)) bus1 ();

    comp_strg_mc #(.DATA_W(32), .ADDR_W(4), .SAT_EN(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    comp_strg_mc #(.DATA_W(32), .ADDR_W(4), .SAT_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic set_in(input cmd_e c, input int a, input int b, input int cc,
                          input logic [31:0] d, input logic e);
        logic [3:0] a4, b4, c4;
        a4 = a[3:0]; b4 = b[3:0]; c4 = cc[3:0];
        bus0.cmd = c; bus0.addA = a4; bus0.addB = b4; bus0.addC = c4; bus0.din = d; bus0.en = e;
        bus1.cmd = c; bus1.addA = a4; bus1.addB = b4; bus1.addC = c4; bus1.din = d; bus1.en = e;
    endtask

    // Reference behaviour of one command against one storage image
    task automatic model(input cmd_e c, input int a, input int b, input int cc, input logic [31:0] d,
                         input bit sat, output logic [31:0] r, output logic e, output logic o);
        logic [31:0] mm [16];
        logic [32:0] w;
        if (sat) mm = m1; else mm = m0;
        r = 32'h0; e = 1'b0; o = 1'b0;
        case (c)
            CMD_READ:  r = mm[a];
            CMD_WRITE: begin mm[a] = d; r = d; end
            CMD_ADD: if (a == b) e = 1'b1;
                     else begin
                         w = {1'b0, mm[a]} + {1'b0, mm[b]};
                         o = w[32];
                         r = (sat && o) ? 32'hFFFF_FFFF : w[31:0];
                         mm[cc] = r;
                     end
            CMD_SUB: if (a == b) e = 1'b1;
                     else begin
                         o = (mm[a] < mm[b]);
                         r = (sat && o) ? 32'h0 : (mm[a] - mm[b]);
                         mm[cc] = r;
                     end
            CMD_AND: begin r = mm[a] & mm[b]; mm[cc] = r; end
            CMD_OR:  begin r = mm[a] | mm[b]; mm[cc] = r; end
            CMD_XOR: begin r = mm[a] ^ mm[b]; mm[cc] = r; end
            default: e = 1'b1;
        endcase
        if (sat) m1 = mm; else m0 = mm;
    endtask

    task automatic push_exp(input cmd_e c, input int a, input int b, input int cc, input logic [31:0] d);
        exp_t x;
        logic o1, e1;
        model(c, a, b, cc, d, 1'b0, x.d0, x.err, x.ovf);
        model(c, a, b, cc, d, 1'b1, x.d1, e1, o1);
        sb.push_back(x);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus0.ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", bus0.ready, 32'd1);
    endtask

    // One command with en pulsed; checks the two-cycle response latency
    task automatic issue(input cmd_e c, input int a, input int b, input int cc, input logic [31:0] d);
        wait_ready();
        set_in(c, a, b, cc, d, 1'b1);
        push_exp(c, a, b, cc, d);
        @(posedge clk);
        @(negedge clk);
        set_in(c, a, b, cc, d, 1'b0);
        chk("lat_exec_valid", bus0.valid_out, 32'd0);
        @(negedge clk);
        chk("lat_resp_valid", bus0.valid_out, 32'd1);
    endtask

    always @(posedge clk) begin
        if (bus0.en && bus0.ready) acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    // Scoreboard: every response pops one expectation
    always @(negedge clk) begin : mon
        exp_t x;
        if (bus0.valid_out) begin
            chk("sb_nonempty", (sb.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("dout_wrap", bus0.dout, x.d0);
                chk("dout_sat",  bus1.dout, x.d1);
                chk("err_wrap",  bus0.err,  x.err);
                chk("err_sat",   bus1.err,  x.err);
                chk("ovf_wrap",  bus0.ovf,  x.ovf);
                chk("ovf_sat",   bus1.ovf,  x.ovf);
                chk("valid_sat", bus1.valid_out, 32'd1);
            end
        end
    end

    initial begin
        int base;
        int t;
        for (int i = 0; i < 16; i++) begin m0[i] = 32'h0; m1[i] = 32'h0; end
        set_in(CMD_READ, 0, 0, 0, 32'h0, 1'b0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus0.ready,     32'd0);
        chk("rst_valid", bus0.valid_out, 32'd0);
        chk("rst_dout",  bus0.dout,      32'd0);
        chk("rst_err",   bus0.err,       32'd0);
        chk("rst_ovf",   bus0.ovf,       32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", bus0.ready, 32'd1);

        issue(CMD_WRITE, 3, 0, 0, 32'h10);
        issue(CMD_READ,  3, 0, 0, 32'h0);
        @(negedge clk);
        chk("hold_dout", bus0.dout, 32'h10);
        chk("hold_valid", bus0.valid_out, 32'd0);

        // Overflow: wrap vs saturate, then readback of the written word
        issue(CMD_WRITE, 1, 0, 0, 32'hFFFF_FFFF);
        issue(CMD_WRITE, 2, 0, 0, 32'h2);
        issue(CMD_ADD,   1, 2, 5, 32'h0);
        issue(CMD_READ,  5, 0, 0, 32'h0);
        issue(CMD_SUB,   2, 1, 8, 32'h0);
        issue(CMD_READ,  8, 0, 0, 32'h0);

        // Rejected commands leave storage untouched
        issue(CMD_WRITE, 6, 0, 0, 32'h66);
        issue(CMD_SUB,   4, 4, 6, 32'h0);
        issue(CMD_RSVD,  1, 2, 6, 32'h0);
        issue(CMD_READ,  6, 0, 0, 32'h0);

        issue(CMD_WRITE, 2, 0, 0, 32'hF0F0);
        issue(CMD_WRITE, 3, 0, 0, 32'hFF00);
        issue(CMD_XOR,   2, 3, 7, 32'h0);
        issue(CMD_AND,   2, 3, 9, 32'h0);
        issue(CMD_OR,    2, 3, 10, 32'h0);

        // Back-to-back with en held high; destination aliases operand A
        issue(CMD_WRITE, 0, 0, 0, 32'h5);
        issue(CMD_WRITE, 1, 0, 0, 32'h7);
        base = acc_q.size();
        set_in(CMD_ADD, 0, 1, 0, 32'h0, 1'b1);
        push_exp(CMD_ADD, 0, 1, 0, 32'h0);
        t = 0;
        while (acc_q.size() < base + 1 && t < 10) begin @(negedge clk); t++; end
        chk("acc_first", acc_q.size(), base + 1);
        set_in(CMD_READ, 0, 0, 0, 32'h0, 1'b1);
        push_exp(CMD_READ, 0, 0, 0, 32'h0);
        t = 0;
        while (acc_q.size() < base + 2 && t < 10) begin @(negedge clk); t++; end
        chk("acc_second", acc_q.size(), base + 2);
        set_in(CMD_READ, 0, 0, 0, 32'h0, 1'b0);
        if (acc_q.size() >= base + 2) chk("accept_spacing", acc_q[base+1] - acc_q[base], 32'd3);
        repeat (3) @(negedge clk);

        // Reset during EXEC aborts the write and clears storage
        wait_ready();
        set_in(CMD_WRITE, 9, 0, 0, 32'hABCD, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        set_in(CMD_WRITE, 9, 0, 0, 32'hABCD, 1'b0);
        @(negedge clk);
        chk("abort_valid", bus0.valid_out, 32'd0);
        chk("abort_ready", bus0.ready,     32'd0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin m0[i] = 32'h0; m1[i] = 32'h0; end
        @(negedge clk);
        chk("release_ready", bus0.ready,     32'd1);
        chk("release_valid", bus0.valid_out, 32'd0);
        chk("release_dout",  bus0.dout,      32'd0);
        issue(CMD_READ, 9, 0, 0, 32'h0);

        repeat (2) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/comp_strg_mc.md
COMP_STRG_MC -- requirements
Module: comp_strg_mc

Interface
REQ-001 Parameter DATA_W, default 32, width of every storage word and data port.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter SAT_EN, default 0, 1 = ADD/SUB saturate, 0 = ADD/SUB wrap.
REQ-004 clk  input  1  single clock, all state updates on posedge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 en  input  1  command request, qualified by ready.
REQ-007 cmd  input  3  operation code, comp_strg_pkg::cmd_e.
REQ-008 addA, addB, addC  input  ADDR_W each  operand A, operand B, destination addresses.
REQ-009 din  input  DATA_W  write data for WRITE.
REQ-010 ready  output  1  block accepts a command this cycle.
REQ-011 valid_out  output  1  one-cycle pulse, response fields valid.
REQ-012 dout  output  DATA_W  response data.
REQ-013 err  output  1  command rejected, qualified by valid_out.
REQ-014 ovf  output  1  arithmetic overflow/underflow, qualified by valid_out.

Function
REQ-015 Opcodes: 0 READ, 1 WRITE, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 reserved.
REQ-016 FSM states IDLE, EXEC, RESP; ready = 1 only in IDLE (combinational from state).
REQ-017 Edge k with IDLE and en=1: latch cmd/addA/addB/addC/din, read mem[addA] and mem[addB] into operand registers, go to EXEC; en=0 stays IDLE.
REQ-018 Edge k+1 (EXEC): compute result, perform memory write, load dout/err/ovf, go to RESP.
REQ-019 RESP: valid_out = 1 for exactly that one cycle; edge k+2 returns to IDLE; max throughput 1 command per 3 cycles.
REQ-020 en while ready=0 is ignored, with no queuing and no effect.
REQ-021 READ: dout = mem[addA], no write.
REQ-022 WRITE: mem[addA] = din, dout = din.
REQ-023 ADD/SUB/AND/OR/XOR: mem[addC] = mem[addA] op mem[addB], dout = written value.
REQ-024 Operand values are those sampled at edge k; addC equal to addA or addB is legal and uses pre-write operands.
REQ-025 ADD/SUB with addA == addB: err = 1, no write, dout = 0.
REQ-026 Opcode 7: err = 1, no write, dout = 0.
REQ-027 Arithmetic is unsigned DATA_W-bit; ADD carry-out or SUB borrow sets ovf = 1.
REQ-028 With SAT_EN=1, an ADD overflow writes all-ones and a SUB underflow writes 0.
REQ-029 With SAT_EN=0, results are modulo 2**DATA_W.
REQ-030 Logical ops and READ/WRITE always drive ovf = 0.
REQ-031 dout, err and ovf hold their value after RESP until the next response.

Reset
REQ-032 rst=1 at any edge forces state IDLE, valid_out=0, dout=0, err=0, ovf=0, all operand/latch registers 0.
REQ-033 rst=1 clears all DEPTH storage words to 0.
REQ-034 rst asserted in EXEC aborts the command: no write, no valid_out.
REQ-035 While rst=1, ready = 0; the first command is accepted at the first edge with rst=0.

Structure
REQ-036 comp_strg_pkg holds cmd_e (3-bit enum), state_e (IDLE/EXEC/RESP), and default DATA_W/ADDR_W localparams.
REQ-037 Sub-module comp_strg_alu (combinational, parametrised DATA_W/SAT_EN) takes op and two operands and returns result, ovf and err_op.
REQ-038 Storage is a flop array inside comp_strg_mc, with no inference of an external RAM macro.

Verification
REQ-039 Reset, then WRITE 0x10 to addr 3 and READ addr 3 -> valid_out 2 cycles after each accept, dout=0x10, err=0.
REQ-040 mem[1]=0xFFFFFFFF, mem[2]=2, ADD A=1 B=2 C=5 -> SAT_EN=0: dout=0x1, ovf=1; SAT_EN=1: dout=0xFFFFFFFF, ovf=1.
REQ-041 SUB A=4 B=4 C=6, and then cmd=7 -> err=1, dout=0, mem[6] unchanged on READ-back.
REQ-042 mem[0]=5, mem[1]=7, ADD A=0 B=1 C=0, then READ 0 -> 12; en held high continuously -> accepts spaced exactly 3 cycles apart.
REQ-043 rst pulsed during EXEC of a WRITE -> no valid_out, ready=1 after release, READ of that address returns 0.
REQ-044 XOR mem[2]=0xF0F0 with mem[3]=0xFF00 into 7 -> dout=0x0FF0, ovf=0.
